// File: rtl/vga_timing_gen_p.sv
// Parametrised VGA raster generator: sync timing, downscaled frame-buffer address and colour mux.
// All outputs lag the stage-0 counters by RAM_LAT+2 CLK; defining VGA_BORDER_EN adds a fixed-colour border.
module vga_timing_gen_p #(
   parameter int H_PW = 96,
   parameter int H_BP = 48,
   parameter int H_DISP = 640,
   parameter int H_FP = 16,
   parameter int V_PW = 2,
   parameter int V_BP = 29,
   parameter int V_DISP = 480,
   parameter int V_FP = 10,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0,
   parameter int CLK_DIV = 1,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_H_W = 8,
   parameter int ADDR_V_W = 7,
   parameter int RAM_LAT = 1,
   parameter int COLOUR_W = 12,
   parameter logic [COLOUR_W-1:0] BORDER_COLOUR = 12'hFFF
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic [2*COLOUR_W-1:0]        CONFIG_COLOURS,
   output logic                         DPR_CLK,
   output logic [ADDR_V_W+ADDR_H_W-1:0] VGA_ADDR,
   input  logic                         VGA_DATA,
   output logic                         VGA_HS,
   output logic                         VGA_VS,
   output logic [COLOUR_W-1:0]          VGA_COLOUR,
   output logic                         DISP_EN,
   output logic                         FRAME_START
);
   localparam int H_TOT = H_PW + H_BP + H_DISP + H_FP;
   localparam int V_TOT = V_PW + V_BP + V_DISP + V_FP;
   localparam int H_W = $clog2(H_TOT);
   localparam int V_W = $clog2(V_TOT);
   localparam logic [H_W-1:0] H_PW_C   = H_W'(H_PW);
   localparam logic [H_W-1:0] H_ST_C   = H_W'(H_PW + H_BP);
   localparam logic [H_W-1:0] H_LAST_C = H_W'(H_PW + H_BP + H_DISP - 1);
   localparam logic [H_W-1:0] H_MAX_C  = H_W'(H_TOT - 1);
   localparam logic [V_W-1:0] V_PW_C   = V_W'(V_PW);
   localparam logic [V_W-1:0] V_ST_C   = V_W'(V_PW + V_BP);
   localparam logic [V_W-1:0] V_LAST_C = V_W'(V_PW + V_BP + V_DISP - 1);
   localparam logic [V_W-1:0] V_MAX_C  = V_W'(V_TOT - 1);

   logic                         w_tick;
   logic                         w_hwrap;
   logic                         w_vwrap;
   logic                         w_act0;
   logic                         w_fs0;
   logic [H_W-1:0]               w_hrel;
   logic [V_W-1:0]               w_vrel;
   logic [ADDR_V_W+ADDR_H_W-1:0] w_addr0;
   logic [COLOUR_W-1:0]          w_colour;
   logic [H_W-1:0]               r_hcnt;
   logic [V_W-1:0]               r_vcnt;
   logic [RAM_LAT:0]             r_hs_p;
   logic [RAM_LAT:0]             r_vs_p;
   logic [RAM_LAT:0]             r_act_p;
   logic [RAM_LAT:0]             r_fs_p;

   assign DPR_CLK = CLK;

   generate
      if (CLK_DIV > 1) begin : g_div
         localparam int DIV_W = $clog2(CLK_DIV);
         localparam logic [DIV_W-1:0] DIV_MAX_C = DIV_W'(CLK_DIV - 1);
         logic [DIV_W-1:0] r_div;
         always_ff @(posedge CLK) begin
            if (RESET || r_div == DIV_MAX_C) r_div <= '0;
            else                             r_div <= r_div + 1'b1;
         end
         assign w_tick = (r_div == DIV_MAX_C);
      end else begin : g_nodiv
         assign w_tick = 1'b1;
      end
   endgenerate

   assign w_hwrap = (r_hcnt == H_MAX_C);
   assign w_vwrap = (r_vcnt == V_MAX_C);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (w_tick) begin
         if (w_hwrap) begin
            r_hcnt <= '0;
            r_vcnt <= w_vwrap ? '0 : r_vcnt + 1'b1;
         end else begin
            r_hcnt <= r_hcnt + 1'b1;
         end
      end
   end

   assign w_act0  = (r_hcnt >= H_ST_C) && (r_hcnt <= H_LAST_C) && (r_vcnt >= V_ST_C) && (r_vcnt <= V_LAST_C);
   assign w_hrel  = r_hcnt - H_ST_C;
   assign w_vrel  = r_vcnt - V_ST_C;
   assign w_addr0 = w_act0 ? {ADDR_V_W'(w_vrel >> SCALE_SHIFT), ADDR_H_W'(w_hrel >> SCALE_SHIFT)} : '0;
   assign w_fs0   = w_act0 && (r_hcnt == H_ST_C) && (r_vcnt == V_ST_C) && w_tick;

   // Index 0 is stage 1 (aligned with VGA_ADDR); index RAM_LAT is aligned with VGA_DATA.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         VGA_ADDR <= '0;
         r_hs_p   <= '0;
         r_vs_p   <= '0;
         r_act_p  <= '0;
         r_fs_p   <= '0;
      end else begin
         VGA_ADDR <= w_addr0;
         r_hs_p   <= {r_hs_p[RAM_LAT-1:0], (r_hcnt < H_PW_C)};
         r_vs_p   <= {r_vs_p[RAM_LAT-1:0], (r_vcnt < V_PW_C)};
         r_act_p  <= {r_act_p[RAM_LAT-1:0], w_act0};
         r_fs_p   <= {r_fs_p[RAM_LAT-1:0], w_fs0};
      end
   end

`ifdef VGA_BORDER_EN
   logic             w_bd0;
   logic [RAM_LAT:0] r_bd_p;
   assign w_bd0 = w_act0 && ((r_hcnt == H_ST_C) || (r_hcnt == H_LAST_C) ||
                             (r_vcnt == V_ST_C) || (r_vcnt == V_LAST_C));
   always_ff @(posedge CLK) begin
      if (RESET) r_bd_p <= '0;
      else       r_bd_p <= {r_bd_p[RAM_LAT-1:0], w_bd0};
   end
   always_comb begin
      w_colour = '0;
      if (r_act_p[RAM_LAT]) begin
         if (r_bd_p[RAM_LAT]) w_colour = BORDER_COLOUR;
         else if (VGA_DATA)   w_colour = CONFIG_COLOURS[2*COLOUR_W-1:COLOUR_W];
         else                 w_colour = CONFIG_COLOURS[COLOUR_W-1:0];
      end
   end
`else
   always_comb begin
      w_colour = '0;
      if (r_act_p[RAM_LAT]) begin
         if (VGA_DATA) w_colour = CONFIG_COLOURS[2*COLOUR_W-1:COLOUR_W];
         else          w_colour = CONFIG_COLOURS[COLOUR_W-1:0];
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         VGA_HS      <= ~HS_POL;
         VGA_VS      <= ~VS_POL;
         VGA_COLOUR  <= '0;
         DISP_EN     <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         VGA_HS      <= r_hs_p[RAM_LAT] ? HS_POL : ~HS_POL;
         VGA_VS      <= r_vs_p[RAM_LAT] ? VS_POL : ~VS_POL;
         VGA_COLOUR  <= w_colour;
         DISP_EN     <= r_act_p[RAM_LAT];
         FRAME_START <= r_fs_p[RAM_LAT];
      end
   end
endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Scoreboard bench for vga_timing_gen_p on a shrunken raster with random colours, frame buffer and resets.
module tb_vga_timing_gen_p;
   localparam int H_PW = 4, H_BP = 3, H_DISP = 16, H_FP = 2;
   localparam int V_PW = 2, V_BP = 2, V_DISP = 8, V_FP = 1;
   localparam logic HS_P = 1'b1, VS_P = 1'b0;
   localparam int CLK_DIV = 2, SCALE_SHIFT = 1, ADDR_H_W = 3, ADDR_V_W = 2, RAM_LAT = 2;
   localparam logic [11:0] BORDER = 12'hA5C;
   localparam int H_TOT = H_PW + H_BP + H_DISP + H_FP;
   localparam int V_TOT = V_PW + V_BP + V_DISP + V_FP;
   localparam int H_ST = H_PW + H_BP, V_ST = V_PW + V_BP;
   localparam int LAT = RAM_LAT + 2;
   localparam int AW = ADDR_V_W + ADDR_H_W;
   localparam int NCYC = 3600;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic [23:0]   CONFIG_COLOURS = 24'hF00_00F;
   logic          DPR_CLK;
   logic [AW-1:0] VGA_ADDR;
   logic          VGA_DATA = 1'b0;
   logic          VGA_HS, VGA_VS, DISP_EN, FRAME_START;
   logic [11:0]   VGA_COLOUR;

   vga_timing_gen_p #(
      .H_PW(H_PW), .H_BP(H_BP), .H_DISP(H_DISP), .H_FP(H_FP),
      .V_PW(V_PW), .V_BP(V_BP), .V_DISP(V_DISP), .V_FP(V_FP),
      .HS_POL(HS_P), .VS_POL(VS_P), .CLK_DIV(CLK_DIV), .SCALE_SHIFT(SCALE_SHIFT),
      .ADDR_H_W(ADDR_H_W), .ADDR_V_W(ADDR_V_W), .RAM_LAT(RAM_LAT),
      .COLOUR_W(12), .BORDER_COLOUR(BORDER)
   ) dut (
      .CLK(CLK), .RESET(RESET), .CONFIG_COLOURS(CONFIG_COLOURS), .DPR_CLK(DPR_CLK),
      .VGA_ADDR(VGA_ADDR), .VGA_DATA(VGA_DATA), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_COLOUR(VGA_COLOUR), .DISP_EN(DISP_EN), .FRAME_START(FRAME_START)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic          dpr;
      logic          hs;
      logic          vs;
      logic [11:0]   col;
      logic          de;
      logic          fs;
      logic [AW-1:0] addr;
   } obs_t;

   obs_t        exp_q[$];
   logic [AW-1:0] aq[$];
   logic        rst_h [0:NCYC+7];
   logic [23:0] col_h [0:NCYC+7];
   logic        mem [0:(1<<AW)-1];
   int n_cmp = 0, n_err = 0;
   int n_fs_exp = 0, n_fs_seen = 0;

   // Raster position n CLK after reset release, straight from the timing rules.
   function automatic void raster(input int n, output logic hs, output logic vs, output logic act,
                                  output logic fs, output logic bd, output logic [AW-1:0] addr);
      int t, h, v;
      t = n / CLK_DIV;
      h = t % H_TOT;
      v = (t / H_TOT) % V_TOT;
      hs = (h < H_PW);
      vs = (v < V_PW);
      act = (h >= H_ST) && (h < H_ST + H_DISP) && (v >= V_ST) && (v < V_ST + V_DISP);
      fs = act && (h == H_ST) && (v == V_ST) && ((n % CLK_DIV) == CLK_DIV - 1);
      bd = act && (h == H_ST || h == H_ST + H_DISP - 1 || v == V_ST || v == V_ST + V_DISP - 1);
      addr = act ? AW'((((v - V_ST) >> SCALE_SHIFT) % (1 << ADDR_V_W)) * (1 << ADDR_H_W)
                       + (((h - H_ST) >> SCALE_SHIFT) % (1 << ADDR_H_W))) : '0;
   endfunction

   function automatic int last_rst(input int x);
      for (int j = x - 1; j >= 0; j--) if (rst_h[j]) return j;
      return -1;
   endfunction

   function automatic logic any_rst(input int a, input int b);
      for (int j = a; j <= b; j++) if (rst_h[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic obs_t expect_at(input int k);
      obs_t e;
      int s;
      logic hs, vs, act, fs, bd;
      logic [AW-1:0] a;
      logic [23:0] cc;
      s = k - LAT;
      cc = col_h[k-1];
      e = '0;
      e.hs = ~HS_P;
      e.vs = ~VS_P;
      if (!any_rst((s < 0) ? 0 : s, k - 1)) begin
         raster(s - (last_rst(s) + 1), hs, vs, act, fs, bd, a);
         e.hs = hs ? HS_P : ~HS_P;
         e.vs = vs ? VS_P : ~VS_P;
         e.de = act;
         e.fs = fs;
         if (act) e.col = mem[a] ? cc[23:12] : cc[11:0];
`ifdef VGA_BORDER_EN
         if (bd) e.col = BORDER;
`endif
      end
      if (!rst_h[k-1]) begin
         raster(k - 1 - (last_rst(k - 1) + 1), hs, vs, act, fs, bd, a);
         e.addr = a;
      end
      return e;
   endfunction

   // Stimulus, frame-buffer model and expectation push.
   initial begin
      int rst_left, rst_at1, rst_at2;
      obs_t e;
      rst_left = 4;
      rst_at1 = 1400 + $urandom_range(0, 300);
      rst_at2 = 2700 + $urandom_range(0, 300);
      foreach (mem[i]) mem[i] = 1'($urandom);
      for (int k = 0; k < NCYC; k++) begin
         @(posedge CLK);
         #1;
         if (k >= 1) begin
            e = expect_at(k);
            if (e.fs) n_fs_exp++;
            exp_q.push_back(e);
         end
         if (k == rst_at1 || k == rst_at2) rst_left = $urandom_range(1, 3);
         if (rst_left > 0) begin
            RESET = 1'b1;
            rst_left--;
         end else begin
            RESET = 1'b0;
         end
         if ($urandom_range(0, 149) == 0) CONFIG_COLOURS = 24'($urandom);
         rst_h[k] = RESET;
         col_h[k] = CONFIG_COLOURS;
         aq.push_back(VGA_ADDR);
         if (aq.size() > RAM_LAT) VGA_DATA = mem[aq.pop_front()];
      end
      @(negedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (n_fs_seen != n_fs_exp) begin
         n_err++;
         $display("FAIL frame_start_count: got %0d, expected %0d", n_fs_seen, n_fs_exp);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Monitor: per-cycle scoreboard plus pulse-width and frame-period checks.
   int   mcyc = 0, last_rst_m = -1000;
   int   hs_start = -1, vs_start = -1, fs_prev = -1;
   logic hs_in = 1'b0, vs_in = 1'b0;
   always @(negedge CLK) begin
      obs_t e, a;
      if (RESET) last_rst_m = mcyc;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {DPR_CLK, VGA_HS, VGA_VS, VGA_COLOUR, DISP_EN, FRAME_START, VGA_ADDR};
         n_cmp++;
         if (a !== e) begin
            n_err++;
            $display("FAIL outputs@%0d: got dpr=%b hs=%b vs=%b col=%h de=%b fs=%b addr=%h, expected dpr=%b hs=%b vs=%b col=%h de=%b fs=%b addr=%h",
                     mcyc, a.dpr, a.hs, a.vs, a.col, a.de, a.fs, a.addr,
                     e.dpr, e.hs, e.vs, e.col, e.de, e.fs, e.addr);
         end
      end
      if (FRAME_START === 1'b1) begin
         n_fs_seen++;
         if (fs_prev > last_rst_m + LAT) begin
            n_cmp++;
            if (mcyc - fs_prev != H_TOT * V_TOT * CLK_DIV) begin
               n_err++;
               $display("FAIL frame_period: got %0d, expected %0d", mcyc - fs_prev, H_TOT * V_TOT * CLK_DIV);
            end
         end
         fs_prev = mcyc;
      end
      if ((VGA_HS === HS_P) && !hs_in) hs_start = mcyc;
      if ((VGA_HS !== HS_P) && hs_in && hs_start > last_rst_m + LAT) begin
         n_cmp++;
         if (mcyc - hs_start != H_PW * CLK_DIV) begin
            n_err++;
            $display("FAIL hs_width: got %0d, expected %0d", mcyc - hs_start, H_PW * CLK_DIV);
         end
      end
      hs_in = (VGA_HS === HS_P);
      if ((VGA_VS === VS_P) && !vs_in) vs_start = mcyc;
      if ((VGA_VS !== VS_P) && vs_in && vs_start > last_rst_m + LAT) begin
         n_cmp++;
         if (mcyc - vs_start != V_PW * H_TOT * CLK_DIV) begin
            n_err++;
            $display("FAIL vs_width: got %0d, expected %0d", mcyc - vs_start, V_PW * H_TOT * CLK_DIV);
         end
      end
      vs_in = (VGA_VS === VS_P);
      mcyc++;
   end
endmodule

// File: doc/vga_timing_gen_p.md
Name: vga_timing_gen_p

Overview:
Parametrised VGA raster generator, successor to the fixed 640x480 signal generator. Provides:
- Fully parameterised horizontal and vertical timing, sync polarity and an on-chip pixel-clock divider.
- Power-of-two downscaled frame-buffer addressing.
- A configurable RAM read latency, with a delay pipeline that keeps HS, VS and colour aligned.

Sits between the frame buffer (dual-port RAM read side) and the VGA connector pins, and exports frame/display status to the top level.

Parameters:
H_PW, 96, horizontal sync pulse width in pixel ticks
H_BP, 48, horizontal back porch in ticks
H_DISP, 640, horizontal active pixels
H_FP, 16, horizontal front porch in ticks
V_PW, 2, vertical sync width in lines
V_BP, 29, vertical back porch in lines
V_DISP, 480, vertical active lines
V_FP, 10, vertical front porch in lines
HS_POL, 0, active level of VGA_HS during the pulse
VS_POL, 0, active level of VGA_VS during the pulse
CLK_DIV, 1, CLK cycles per pixel tick (>=1)
SCALE_SHIFT, 2, log2 of pixel replication in both axes
ADDR_H_W, 8, horizontal frame-buffer address bits
ADDR_V_W, 7, vertical frame-buffer address bits
RAM_LAT, 1, CLK cycles from VGA_ADDR to valid VGA_DATA (>=1)
COLOUR_W, 12, colour bus width
BORDER_COLOUR, 12'hFFF, border colour (optional feature only)

Ports:
CLK  in  1  system clock; also driven out as DPR_CLK
RESET  in  1  synchronous, active-high reset
CONFIG_COLOURS  in  2*COLOUR_W  [2W-1:W] foreground, [W-1:0] background
DPR_CLK  out  1  frame-buffer read clock, equal to CLK
VGA_ADDR  out  ADDR_V_W+ADDR_H_W  {row, col} read address
VGA_DATA  in  1  frame-buffer pixel bit
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
VGA_COLOUR  out  COLOUR_W  pixel colour
DISP_EN  out  1  high while VGA_COLOUR carries an active pixel
FRAME_START  out  1  one-CLK pulse on the first active pixel of each frame

Behaviour:
- Derived constants: H_TOT=H_PW+H_BP+H_DISP+H_FP; V_TOT likewise; H_ST=H_PW+H_BP; V_ST=V_PW+V_BP. Counter widths = clog2 of the totals.
- Divider: counts 0..CLK_DIV-1 and issues tick when it equals CLK_DIV-1. With CLK_DIV=1, tick is constant 1.
- Counters (stage 0):
  - hcnt increments on tick and wraps from H_TOT-1 to 0.
  - vcnt increments on a tick where hcnt wraps, and wraps from V_TOT-1 to 0.
- Active region: act0 = (H_ST<=hcnt<H_ST+H_DISP) && (V_ST<=vcnt<V_ST+V_DISP).
- Stage 1 (registered every CLK):
  - VGA_ADDR = {((vcnt-V_ST)>>SCALE_SHIFT), ((hcnt-H_ST)>>SCALE_SHIFT)}, each field truncated to its width; 0 when !act0.
  - The same stage registers hs1 (hcnt<H_PW), vs1 (vcnt<V_PW), act1, and fs1 = act0 && hcnt==H_ST && vcnt==V_ST && tick.
- Stages 2..RAM_LAT+1: shift register delays hs, vs, act and fs by RAM_LAT cycles.
- Output register, RAM_LAT+2 cycles after stage 0:
  - VGA_HS = hs ? HS_POL : ~HS_POL (VS likewise with VS_POL).
  - VGA_COLOUR = act ? (VGA_DATA ? fg : bg) : 0.
  - DISP_EN = act; FRAME_START = fs.
- Fixed latency of RAM_LAT+2 CLK applies identically to every output; sync edges never skew relative to colour.
- Reset (also mid-frame): divider, hcnt and vcnt = 0; all pipeline stages flushed to inactive.
  - Outputs the cycle after RESET: VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_COLOUR=0, VGA_ADDR=0, DISP_EN=0, FRAME_START=0.
  - The frame restarts from hcnt=vcnt=0 on the first cycle after RESET deasserts.
- Simultaneous H and V wrap: both counters go to 0 on the same tick.
- Only active pixels may drive nonzero colour; porch and sync colour is always 0.

Optional Feature:
VGA_BORDER_EN.
- Defined: an active pixel on the first or last active column or row (hcnt==H_ST, H_ST+H_DISP-1, vcnt==V_ST, V_ST+V_DISP-1) outputs BORDER_COLOUR regardless of VGA_DATA. The border flag travels through the same delay pipeline.
- Undefined: no border logic; colour comes from VGA_DATA only.

Test Plan:
- Default params, run 2 frames -> frame period 800x521=416800 CLK; VGA_HS low 96 CLK per line; VGA_VS low 2 lines (1600 CLK); FRAME_START pulses once per frame, first 3 CLK after stage-0 hcnt=144, vcnt=31.
- Default, hcnt=149, vcnt=40 -> VGA_ADDR=15'h0201 next CLK; with VGA_DATA=1 and CONFIG_COLOURS=24'hF00_00F, VGA_COLOUR=12'hF00 and DISP_EN=1 two CLK later; VGA_DATA=0 -> 12'h00F.
- Blanking check: hcnt=100 with VGA_DATA forced 1 -> VGA_COLOUR=0, DISP_EN=0, VGA_ADDR=0.
- CLK_DIV=4, RAM_LAT=3 -> HS low 384 CLK; frame period 1667200 CLK; HS/colour alignment unchanged, latency 5 CLK.
- HS_POL=1, VS_POL=1 -> sync pulses high; RESET asserted at hcnt=500, vcnt=200 for 3 CLK -> next cycle outputs HS=0, VS=0, COLOUR=0; after release, counting restarts at 0 and a full frame follows.
- VGA_BORDER_EN defined, VGA_DATA=0 -> pixels (144,31) and (783,510) show 12'hFFF; interior pixel (300,200) shows the background colour.
